pixel_writeback_unit: RTL

// - Downstream of the per-lane 8-bit pixel ALUs. Accepts packed vector results (LANES x PIX_W) over valid/ready.
// - Buffers results in a small FIFO and writes them as consecutive words to data memory, starting at base_addr.
// - Sequences one vector job: start -> word_count writes -> done pulse. Decouples ALU throughput from memory stalls.

---
 rtl/vcpu_pkg.sv | 16 +
 rtl/pixel_wb_fifo.sv | 49 ++++
 rtl/pixel_writeback_unit.sv | 135 +++++++++++++
 3 files changed

// File: rtl/vcpu_pkg.sv
// Shared types and constants for the vector pixel datapath.
package vcpu_pkg;

    localparam int VCPU_LANES = 4;
    localparam int VCPU_PIX_W = 8;

    typedef logic [VCPU_LANES*VCPU_PIX_W-1:0] vec_word_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } wb_state_t;

endpackage

// File: rtl/pixel_wb_fifo.sv
// Synchronous show-ahead FIFO buffering pixel result words ahead of memory.
// Pointers carry one extra wrap bit so full and empty are told apart.
module pixel_wb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign head  = mem[rd_ptr_reg[AW-1:0]];

    // Pointer update; reset empties the buffer without touching storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
        end
    end

    // Storage write; contents are don't-care until a push lands.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg[AW-1:0]] <= din;
    end

endmodule

// File: rtl/pixel_writeback_unit.sv
// Pixel writeback unit: buffers ALU vector results and writes them to
// consecutive memory words for one job (start -> word_count writes -> done).
// Optional feature macro: WB_CHECKSUM_EN adds a 16-bit running pixel checksum.
module pixel_writeback_unit
    import vcpu_pkg::*;
#(
    parameter int LANES      = VCPU_LANES,
    parameter int PIX_W      = VCPU_PIX_W,
    parameter int ADDR_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR_W-1:0]      base_addr,
    input  logic [ADDR_W-1:0]      word_count,
    input  logic                   res_valid,
    input  logic [LANES*PIX_W-1:0] res_data,
    output logic                   res_ready,
    output logic                   mem_we,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [LANES*PIX_W-1:0] mem_wdata,
    input  logic                   mem_ack,
    output logic                   busy,
    output logic                   done
`ifdef WB_CHECKSUM_EN
    ,
    output logic [15:0]            checksum
`endif
);

    localparam int W = LANES * PIX_W;

    wb_state_t         state_reg;
    wb_state_t         state_next;
    logic [ADDR_W-1:0] base_reg;
    logic [ADDR_W-1:0] count_reg;
    logic [ADDR_W-1:0] accept_cnt_reg;
    logic [ADDR_W-1:0] write_cnt_reg;

    logic              start_ok;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [W-1:0]      fifo_head;

    pixel_wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (res_data),
        .pop   (pop),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign start_ok  = (state_reg == IDLE) && start;
    assign busy      = (state_reg == RUN) || (state_reg == DRAIN);
    assign done      = (state_reg == DONE);
    // Accept side depends only on registered state, never on mem_ack.
    assign res_ready = (state_reg == RUN) && !fifo_full && (accept_cnt_reg < count_reg);
    assign push      = res_valid && res_ready;
    assign mem_we    = busy && !fifo_empty;
    assign pop       = mem_we && mem_ack;
    assign mem_addr  = base_reg + write_cnt_reg;
    // Head is masked while empty so stale storage never shows on the bus.
    assign mem_wdata = fifo_empty ? '0 : fifo_head;

    // Job parameter latch and accept/write progress counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_reg       <= '0;
            count_reg      <= '0;
            accept_cnt_reg <= '0;
            write_cnt_reg  <= '0;
        end else if (start_ok) begin
            base_reg       <= base_addr;
            count_reg      <= word_count;
            accept_cnt_reg <= '0;
            write_cnt_reg  <= '0;
        end else begin
            if (push) accept_cnt_reg <= accept_cnt_reg + ADDR_W'(1);
            if (pop)  write_cnt_reg  <= write_cnt_reg + ADDR_W'(1);
        end
    end

    // Job state register.
    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // Job sequencing: run until all words accepted, drain until all written.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = (word_count == '0) ? DONE : RUN;
            RUN:     if (accept_cnt_reg == count_reg) state_next = DRAIN;
            DRAIN:   if (write_cnt_reg == count_reg) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

`ifdef WB_CHECKSUM_EN
    logic [15:0] lane_ext [LANES];
    logic [15:0] word_sum;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_ext[gi] = 16'(fifo_head[gi*PIX_W +: PIX_W]);
        end
    endgenerate

    // Sum of all lanes of the word currently at the FIFO head.
    always_comb begin
        word_sum = '0;
        for (int i = 0; i < LANES; i++) word_sum = word_sum + lane_ext[i];
    end

    // Running checksum: cleared per job, accumulates each acked write.
    always_ff @(posedge clk) begin
        if (rst)           checksum <= '0;
        else if (start_ok) checksum <= '0;
        else if (pop)      checksum <= checksum + word_sum;
    end
`endif

endmodule
